// File: rtl/sr_latch.sv
// Clocked SR storage element with one state bit.
// Reset, set and clear are all sampled on the rising edge of clk, so the
// outputs change only at that edge and depend only on the stored bit.
// When S and R are both high, the bit holds its value. qb is always the
// inverse of q.
module sr_latch #(
    parameter logic INIT_Q = 1'b0
) (
    input  logic S,
    input  logic R,
    input  logic reset,
    input  logic clk,
    output logic q,
    output logic qb
);

    // The register starts at INIT_Q, so q is defined before any reset.
    logic q_reg = INIT_Q;
    logic q_next;

    // Next-state selection. Reset has top priority. S=R=1 holds, the
    // same as S=R=0.
    always_comb begin
        q_next = q_reg;
        if (reset) begin
            q_next = INIT_Q;
        end else begin
            case ({S, R})
                2'b01:   q_next = 1'b0;
                2'b10:   q_next = 1'b1;
                default: q_next = q_reg;
            endcase
        end
    end

    // State update happens only at the rising edge.
    always_ff @(posedge clk) begin
        q_reg <= q_next;
    end

    // Both outputs are taken straight from the register, with no logic in
    // the path from the inputs.
    assign q  = q_reg;
    assign qb = ~q_reg;

endmodule

// File: tb/tb_sr_latch.sv
// Scoreboard bench for sr_latch.
// Two instances share the same stimulus: dut0 has INIT_Q=0 and dut1 has
// INIT_Q=1. The driver sets the inputs at each falling edge and pushes the
// hand-computed {q0, q1} expected after the next rising edge. The monitor
// pops one entry just after each rising edge and compares both q and qb of
// both instances against it.
module tb_sr_latch;

    logic clk = 1'b0;
    logic s = 1'b0;
    logic r = 1'b0;
    logic rst = 1'b0;
    logic q0, qb0, q1, qb1;

    int checks = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    string      exp_name[$];

    sr_latch #(.INIT_Q(1'b0)) dut0 (
        .S(s), .R(r), .reset(rst), .clk(clk), .q(q0), .qb(qb0)
    );
    sr_latch #(.INIT_Q(1'b1)) dut1 (
        .S(s), .R(r), .reset(rst), .clk(clk), .q(q1), .qb(qb1)
    );

    always #5 clk = ~clk;

    // One transaction: these inputs are present at the next rising edge.
    // glitch selects a pulse between edges: 1 pulses S, 2 pulses R,
    // 3 pulses reset. The pulse ends well before the edge.
    task automatic apply(input string name, input logic sv, input logic rv,
                         input logic rstv, input logic e0, input logic e1,
                         input int glitch);
        @(negedge clk);
        s = sv;
        r = rv;
        rst = rstv;
        exp_q.push_back({e0, e1});
        exp_name.push_back(name);
        if (glitch != 0) begin
            #1;
            if (glitch == 1) s = 1'b1;
            if (glitch == 2) r = 1'b1;
            if (glitch == 3) rst = 1'b1;
            #2;
            s = sv;
            r = rv;
            rst = rstv;
        end
    endtask

    // Monitor: one entry is popped and compared just after each rising edge.
    initial begin
        logic [1:0] e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = exp_name.pop_front();
                checks += 4;
                if (q0 !== e[1]) begin
                    failures++;
                    $display("FAIL %s q(INIT0): got %b want %b", n, q0, e[1]);
                end
                if (qb0 !== ~e[1]) begin
                    failures++;
                    $display("FAIL %s qb(INIT0): got %b want %b", n, qb0, ~e[1]);
                end
                if (q1 !== e[0]) begin
                    failures++;
                    $display("FAIL %s q(INIT1): got %b want %b", n, q1, e[0]);
                end
                if (qb1 !== ~e[0]) begin
                    failures++;
                    $display("FAIL %s qb(INIT1): got %b want %b", n, qb1, ~e[0]);
                end
                $display("txn %-10s S=%b R=%b rst=%b -> q0=%b qb0=%b q1=%b qb1=%b",
                         n, s, r, rst, q0, qb0, q1, qb1);
            end
        end
    end

    // Driver: directed vectors, each with its hand-computed expectations.
    initial begin
        int wait_cycles;
        // Power-up with no reset applied: outputs already show INIT_Q.
        apply("pwr_idle0", 0, 0, 0, 0, 1, 0);
        apply("pwr_idle1", 0, 0, 0, 0, 1, 0);
        apply("pwr_idle2", 0, 0, 0, 0, 1, 0);
        apply("reset",     0, 0, 1, 0, 1, 0);
        // Clear, then set, then hold.
        apply("clear",     0, 1, 0, 0, 0, 0);
        apply("set",       1, 0, 0, 1, 1, 0);
        apply("hold0",     0, 0, 0, 1, 1, 0);
        apply("hold1",     0, 0, 0, 1, 1, 0);
        apply("set_again", 1, 0, 0, 1, 1, 0);
        // S=R=1 holds a 1, and later holds a 0.
        apply("both_q1a",  1, 1, 0, 1, 1, 0);
        apply("both_q1b",  1, 1, 0, 1, 1, 0);
        apply("both_q1c",  1, 1, 0, 1, 1, 0);
        apply("clear2",    0, 1, 0, 0, 0, 0);
        apply("clr_again", 0, 1, 0, 0, 0, 0);
        apply("both_q0",   1, 1, 0, 0, 0, 0);
        // Reset wins over S, and is held with S high.
        apply("set3",      1, 0, 0, 1, 1, 0);
        apply("rst_s_a",   1, 0, 1, 0, 1, 0);
        apply("rst_s_b",   1, 0, 1, 0, 1, 0);
        apply("rst_s_c",   1, 0, 1, 0, 1, 0);
        apply("post_rst",  1, 0, 0, 1, 1, 0);
        // Reset also wins over R.
        apply("rst_r",     0, 1, 1, 0, 1, 0);
        apply("clear3",    0, 1, 0, 0, 0, 0);
        apply("set4",      1, 0, 0, 1, 1, 0);
        // Pulses between edges must not change the state.
        apply("glitch_r",  0, 0, 0, 1, 1, 2);
        apply("glitch_rs", 0, 0, 0, 1, 1, 3);
        apply("clear4",    0, 1, 0, 0, 0, 0);
        apply("glitch_s",  0, 0, 0, 0, 0, 1);
        apply("glitch_rs2",0, 0, 0, 0, 0, 3);

        // Wait for the monitor to drain the scoreboard, with a cycle budget.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Watchdog: stop the run if it goes on far past its expected length.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
